// File: rtl/dav_pkg.sv
// Shared types and defaults for the spectrum-analysis display path.
// Holds the scan FSM states, the default magnitude width and the bin index type.
package dav_pkg;

  localparam int MAG_W_DEF   = 16;
  localparam int SAMPLES_DEF = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} scan_state_t;

  typedef logic [$clog2(SAMPLES_DEF)-1:0] bin_idx_t;

  // First bin allowed to compete for the peak; bin 0 carries DC when skipped.
  function automatic int firstEligible(input bit skipDc);
    return skipDc ? 1 : 0;
  endfunction

endpackage

// File: rtl/max_tracker.sv
// Running-maximum tracker for tagged magnitude beats.
// max_val/max_idx already include the beat being presented, so the final bin is usable on its arrival edge.
module max_tracker
  import dav_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             valid,
  input  logic [MAG_W-1:0] data,
  input  logic [IDX_W-1:0] tag,
  output logic [MAG_W-1:0] max_val,
  output logic [IDX_W-1:0] max_idx
);

  logic [MAG_W-1:0] maxReg;
  logic [IDX_W-1:0] idxReg;
  logic             take;

  // Strict greater-than keeps the lowest index on ties; init overwrites any older maximum.
  always_comb begin
    take    = valid && (init || (data > maxReg));
    max_val = take ? data : maxReg;
    max_idx = take ? tag  : idxReg;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      maxReg <= '0;
      idxReg <= '0;
    end else begin
      maxReg <= max_val;
      idxReg <= max_idx;
    end
  end

endmodule

// File: rtl/peak_bin_finder.sv
// Reads one frame of FFT magnitudes from the selected ping-pong bank and reports the peak bin.
// done/index_holder/tone_present are held until the next accepted frame.
module peak_bin_finder
  import dav_pkg::*;
#(
  parameter int          SAMPLES = SAMPLES_DEF,
  parameter int          MAG_W   = MAG_W_DEF,
  parameter bit          SKIP_DC = 1'b1,
  parameter int unsigned MIN_MAG = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_ready,
  input  logic                       frame_bank,
  output logic                       rd_en,
  output logic [$clog2(SAMPLES)-1:0] rd_addr,
  output logic                       whichRAM,
  input  logic [MAG_W-1:0]           rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(SAMPLES)-1:0] index_holder,
  output logic                       tone_present
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(SAMPLES - 1);
  localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(firstEligible(SKIP_DC));
  localparam logic [MAG_W-1:0] MIN_MAG_V = MAG_W'(MIN_MAG);

  scan_state_t      state;
  logic             tagValid;
  logic [IDX_W-1:0] tagAddr;
  logic             eligible;
  logic             firstBeat;
  logic [MAG_W-1:0] maxVal;
  logic [IDX_W-1:0] maxIdx;
  logic             toneNow;

  // Address tag follows the RAM's one-cycle read latency so it lines up with rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tagValid <= 1'b0;
      tagAddr  <= '0;
    end else begin
      tagValid <= rd_en;
      tagAddr  <= rd_addr;
    end
  end

  assign eligible  = tagValid && ((tagAddr != '0) || !SKIP_DC);
  assign firstBeat = tagValid && (tagAddr == FIRST_BIN);
  assign toneNow   = (maxVal >= MIN_MAG_V);

  max_tracker #(
    .MAG_W (MAG_W),
    .IDX_W (IDX_W)
  ) u_max_tracker (
    .clk     (clk),
    .reset   (reset),
    .init    (firstBeat),
    .valid   (eligible),
    .data    (rd_data),
    .tag     (tagAddr),
    .max_val (maxVal),
    .max_idx (maxIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      whichRAM     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      index_holder <= '0;
      tone_present <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_ready) begin
            whichRAM <= frame_bank;
            done     <= 1'b0;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last bin is on rd_data now; the tracker's merged output already includes it.
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
          tone_present <= toneNow;
          index_holder <= toneNow ? maxIdx : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_bin_finder.sv
// Bench for peak_bin_finder: two instances (bin 0 skipped / competing) share a ping-pong RAM model.
// A cycle-level reference derived from the frame contents is compared every cycle, plus literal checks.
module tb_peak_bin_finder;

  localparam int S  = 32;
  localparam int MW = 16;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_ready = 1'b0;
  logic frame_bank = 1'b0;

  logic          aRdEn, bRdEn, aWhich, bWhich, aBusy, bBusy, aDone, bDone, aTone, bTone;
  logic [IW-1:0] aRdAddr, bRdAddr, aIdx, bIdx;
  logic [MW-1:0] aData = '0;
  logic [MW-1:0] bData = '0;
  logic [MW-1:0] mem [2][S];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (aRdEn) aData <= mem[aWhich][aRdAddr];
    if (bRdEn) bData <= mem[bWhich][bRdAddr];
  end

  peak_bin_finder #(.SAMPLES(S), .MAG_W(MW), .SKIP_DC(1'b1), .MIN_MAG(64)) dutA (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .frame_bank(frame_bank),
    .rd_en(aRdEn), .rd_addr(aRdAddr), .whichRAM(aWhich), .rd_data(aData),
    .busy(aBusy), .done(aDone), .index_holder(aIdx), .tone_present(aTone));

  peak_bin_finder #(.SAMPLES(S), .MAG_W(MW), .SKIP_DC(1'b0), .MIN_MAG(64)) dutB (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .frame_bank(frame_bank),
    .rd_en(bRdEn), .rd_addr(bRdAddr), .whichRAM(bWhich), .rd_data(bData),
    .busy(bBusy), .done(bDone), .index_holder(bIdx), .tone_present(bTone));

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // Peak of a frame straight from the rules: lowest index of the largest eligible magnitude.
  function automatic void refPeak(input int bank, input bit skipDc, output int idx, output bit tone);
    int best = -1;
    int bestIdx = 0;
    for (int i = (skipDc ? 1 : 0); i < S; i++) begin
      if (int'(mem[bank][i]) > best) begin
        best = int'(mem[bank][i]);
        bestIdx = i;
      end
    end
    tone = (best >= 64);
    idx  = tone ? bestIdx : 0;
  endfunction

  // Reference: phase k = k-th cycle after the accepting edge (0 = idle).
  int phase = 0;
  bit modelValid = 1'b0;
  bit expBank = 1'b0;
  bit expDone = 1'b0;
  int expAddr = 0;
  int expIdxA = 0, expIdxB = 0;
  bit expToneA = 1'b0, expToneB = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; expBank = 1'b0; expDone = 1'b0; expAddr = 0;
      expIdxA = 0; expIdxB = 0; expToneA = 1'b0; expToneB = 1'b0;
      modelValid = 1'b1;
    end else if (phase == 0) begin
      if (frame_ready) begin
        phase = 1; expBank = frame_bank; expDone = 1'b0;
      end
    end else if (phase == S + 1) begin
      phase = 0; expDone = 1'b1;
      refPeak(int'(expBank), 1'b1, expIdxA, expToneA);
      refPeak(int'(expBank), 1'b0, expIdxB, expToneB);
    end else begin
      phase++;
    end
    if (phase >= 1 && phase <= S) expAddr = phase - 1;
  end

  always @(negedge clk) begin
    logic [14:0] expA, expB;
    bit en;
    if (modelValid) begin
      en   = (phase >= 1) && (phase <= S);
      expA = {en, expAddr[IW-1:0], expBank, phase != 0, expDone, expIdxA[IW-1:0], expToneA};
      expB = {en, expAddr[IW-1:0], expBank, phase != 0, expDone, expIdxB[IW-1:0], expToneB};
      check("cycle A", {17'd0, aRdEn, aRdAddr, aWhich, aBusy, aDone, aIdx, aTone}, {17'd0, expA});
      check("cycle B", {17'd0, bRdEn, bRdAddr, bWhich, bBusy, bDone, bIdx, bTone}, {17'd0, expB});
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic bank);
    frame_ready = 1'b1; frame_bank = bank;
    sync();
    frame_ready = 1'b0;
  endtask

  task automatic fill(input int bank, input int val);
    for (int i = 0; i < S; i++) mem[bank][i] = MW'(val);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!(aDone && bDone) && n < 200) begin
      @(negedge clk); n++;
    end
    check({name, " done"}, {31'd0, aDone && bDone}, 32'd1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((aBusy || bBusy) && n < 200) begin
      sync(); n++;
    end
    check("idle", {30'd0, aBusy, bBusy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fill(0, 0); fill(1, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset rd_en", aRdEn, 0);
    check("reset rd_addr", aRdAddr, 0);
    check("reset busy/done", {aBusy, aDone}, 0);
    check("reset idx/tone", {aIdx, aTone}, 0);
    sync();

    // Ramp: exact latency and address sequence
    for (int i = 0; i < S; i++) mem[0][i] = MW'(i * 10);
    pulse(1'b0);
    @(negedge clk);
    check("ramp addr@1", {aRdEn, aRdAddr}, {1'b1, 5'd0});
    repeat (31) @(negedge clk);
    check("ramp addr@32", {aRdEn, aRdAddr}, {1'b1, 5'd31});
    @(negedge clk);
    check("ramp done@33", {aRdEn, aDone}, 0);
    @(negedge clk);
    check("ramp done@34", aDone, 1);
    check("ramp idx", aIdx, 31);
    check("ramp tone", aTone, 1);
    sync();

    // Ties keep the lowest index
    fill(0, 100); mem[0][5] = 900; mem[0][20] = 900;
    pulse(1'b0); waitDone("tie");
    check("tie idx A", aIdx, 5);
    check("tie idx B", bIdx, 5);
    sync();

    // Quiet frame
    fill(0, 40);
    pulse(1'b0); waitDone("quiet");
    check("quiet tone/idx", {aTone, aIdx}, 0);
    check("quiet done", aDone, 1);
    sync();

    // DC bin handling
    fill(0, 100); mem[0][0] = 5000; mem[0][9] = 300;
    pulse(1'b0); waitDone("dc");
    check("dc skip idx", aIdx, 9);
    check("dc keep idx", bIdx, 0);
    sync();

    // frame_ready during a scan is dropped
    for (int i = 0; i < S; i++) mem[0][i] = MW'(i * 10);
    fill(1, 100); mem[1][7] = 7000;
    pulse(1'b0);
    repeat (9) sync();
    frame_ready = 1'b1; frame_bank = 1'b1;
    sync();
    frame_ready = 1'b0;
    @(negedge clk);
    check("drop whichRAM", {aWhich, aBusy}, {1'b0, 1'b1});
    waitDone("drop");
    check("drop idx", aIdx, 31);
    sync();
    pulse(1'b1);
    @(negedge clk);
    check("bank1 whichRAM/done", {aWhich, aDone}, {1'b1, 1'b0});
    waitDone("bank1");
    check("bank1 idx", aIdx, 7);
    sync();

    // frame_ready on the DRAIN->IDLE edge is not accepted
    pulse(1'b0);
    repeat (32) sync();
    frame_ready = 1'b1; frame_bank = 1'b1;
    sync();
    frame_ready = 1'b0;
    @(negedge clk);
    check("drain collide", {aBusy, aDone, aWhich}, {1'b0, 1'b1, 1'b0});
    sync();

    // Reset mid-scan discards the partial result
    fill(1, 100); mem[1][3] = 60000;
    pulse(1'b1);
    repeat (14) sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("midreset outs", {aRdEn, aRdAddr, aWhich, aBusy, aDone, aIdx, aTone}, 0);
    sync();
    fill(0, 50); mem[0][12] = 2000;
    pulse(1'b0); waitDone("post-reset");
    check("post-reset idx A", aIdx, 12);
    check("post-reset idx B", bIdx, 12);
    sync();

    // Randomized frames with stray frame_ready pulses throughout
    for (int f = 0; f < 30; f++) begin
      int bank, mx;
      waitIdle();
      bank = int'($urandom_range(1));
      for (int i = 0; i < S; i++)
        mem[bank][i] = ($urandom_range(3) == 0) ? MW'($urandom_range(63)) : MW'($urandom_range(65535));
      if ($urandom_range(1) == 1) begin
        mx = int'($urandom_range(65535));
        for (int k = 0; k < 3; k++) mem[bank][$urandom_range(S - 1)] = MW'(mx);
      end
      pulse(bank[0]);
      for (int c = 0; c < S + 4; c++) begin
        frame_ready = ($urandom_range(3) == 0);
        frame_bank  = $urandom_range(1) == 1;
        sync();
      end
      frame_ready = 1'b0;
    end
    waitIdle();
    repeat (3) sync();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
